// File: rtl/clock_display_driver.sv
// clock_display_driver: snapshots hr/min/sec once per frame, converts each field to BCD by repeated
// subtract-ten, and scans the six digits onto a shared 7-segment bus with a blinking dp colon.
module clock_display_driver #(
    parameter int SCAN_DIV   = 1000,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [4:0] i_hr,
    input  logic [5:0] i_min,
    input  logic [5:0] i_sec,
    input  logic [5:0] i_blank_mask,
    output logic [6:0] o_seg,
    output logic       o_dp,
    output logic [5:0] o_an
);
    localparam int PW = $clog2(SCAN_DIV);

    typedef enum logic [1:0] {IDLE, LOAD, CONV, COMMIT} state_t;

    state_t        state, state_nx;
    logic [PW-1:0] pcnt;
    logic [2:0]    idx;
    logic          first, pwrap, frame_start, any_ge, blank;
    logic [4:0]    w_h;
    logic [5:0]    w_m, w_s;
    logic [2:0]    t_h, t_m, t_s;
    logic [3:0]    dig [6];
    logic [5:0]    onehot, an_nx;
    logic [6:0]    seg_nx;
    logic          dp_nx;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h3F;
            4'd1:    seg7 = 7'h06;
            4'd2:    seg7 = 7'h5B;
            4'd3:    seg7 = 7'h4F;
            4'd4:    seg7 = 7'h66;
            4'd5:    seg7 = 7'h6D;
            4'd6:    seg7 = 7'h7D;
            4'd7:    seg7 = 7'h07;
            4'd8:    seg7 = 7'h7F;
            4'd9:    seg7 = 7'h6F;
            default: seg7 = 7'h00;
        endcase
    endfunction

    assign pwrap       = pcnt == PW'(SCAN_DIV - 1);
    assign frame_start = first | (pwrap && idx == 3'd5);
    assign any_ge      = w_h >= 5'd10 || w_m >= 6'd10 || w_s >= 6'd10;

    // first is set by reset so the frame right after release kicks off a conversion
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pcnt  <= '0;
            idx   <= '0;
            first <= 1'b1;
        end else begin
            first <= 1'b0;
            pcnt  <= pwrap ? '0 : pcnt + 1'b1;
            if (pwrap) idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= IDLE;
        else state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = frame_start ? LOAD : IDLE;
            LOAD:    state_nx = CONV;
            CONV:    state_nx = any_ge ? CONV : COMMIT;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            w_h <= '0;
            w_m <= '0;
            w_s <= '0;
            t_h <= '0;
            t_m <= '0;
            t_s <= '0;
            dig <= '{default: '0};
        end else if (state == LOAD) begin
            w_h <= i_hr;
            w_m <= i_min;
            w_s <= i_sec;
            t_h <= '0;
            t_m <= '0;
            t_s <= '0;
        end else if (state == CONV) begin
            if (w_h >= 5'd10) begin
                w_h <= w_h - 5'd10;
                t_h <= t_h + 3'd1;
            end
            if (w_m >= 6'd10) begin
                w_m <= w_m - 6'd10;
                t_m <= t_m + 3'd1;
            end
            if (w_s >= 6'd10) begin
                w_s <= w_s - 6'd10;
                t_s <= t_s + 3'd1;
            end
        end else if (state == COMMIT) begin
            dig[0] <= {1'b0, t_h};
            dig[1] <= w_h[3:0];
            dig[2] <= {1'b0, t_m};
            dig[3] <= w_m[3:0];
            dig[4] <= {1'b0, t_s};
            dig[5] <= w_s[3:0];
        end
    end

    // colon dp on digits 1 and 3 blinks with the parity of the seconds ones digit
    assign onehot = 6'd1 << idx;
    assign blank  = |(i_blank_mask & onehot);
    assign an_nx  = blank ? '0 : onehot;
    assign seg_nx = blank ? '0 : seg7(dig[idx]);
    assign dp_nx  = ~blank & (idx == 3'd1 | idx == 3'd3) & ~dig[5][0];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_an  <= {6{ACTIVE_LOW}};
            o_seg <= {7{ACTIVE_LOW}};
            o_dp  <= ACTIVE_LOW;
        end else begin
            o_an  <= an_nx ^ {6{ACTIVE_LOW}};
            o_seg <= seg_nx ^ {7{ACTIVE_LOW}};
            o_dp  <= dp_nx ^ ACTIVE_LOW;
        end
    end
endmodule
